// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM states, SPI mode map, counter sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01
  } state_e;

  // Mode constants are {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned cnt_width(input int unsigned frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchroniser with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave transceiver: configurable width/mode/bit order, burst frames,
// truncated-frame and overrun reporting into the clk domain.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = 64,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ssel_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned     CW       = cnt_width(FRAME_BITS);
  localparam logic [CW-1:0]   LAST_BIT = CW'(FRAME_BITS - 1);

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic ssel_rise, ssel_fall, ssel_lvl_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(sck),
    .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ssel (
    .clk(clk), .rst(rst), .d_i(ssel_n),
    .level_o(ssel_lvl_unused), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );

  logic lead, trail, sample_edge, shift_edge;

  assign lead        = CPOL ? sck_fall : sck_rise;
  assign trail       = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  state_e                state_q, state_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;

  logic [FRAME_BITS-1:0] rx_next, tx_adv;

  if (MSB_FIRST) begin : g_msb_first
    assign rx_next = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
    assign tx_adv  = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
  end else begin : g_lsb_first
    assign rx_next = {mosi_s, rx_shift_q[FRAME_BITS-1:1]};
    assign tx_adv  = {1'b0, tx_shift_q[FRAME_BITS-1:1]};
  end

  function automatic logic first_bit(input logic [FRAME_BITS-1:0] w);
    return MSB_FIRST ? w[FRAME_BITS-1] : w[0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ack;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;

    case (state_q)
      IDLE: begin
        if (ssel_fall) begin
          state_d    = ACTIVE;
          bitcnt_d   = '0;
          tx_shift_d = tx_data;
          miso_oe_d  = 1'b1;
          miso_d     = CPHA ? 1'b0 : first_bit(tx_data);
        end
      end

      ACTIVE: begin
        if (sample_edge) begin
          rx_shift_d = rx_next;
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d   = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
            // CPHA=1 presents the next word's first bit on the coming lead edge.
            if (CPHA) tx_shift_d = tx_data;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          if (bitcnt_q == '0) begin
            // Frame start: CPHA=0 reloads after the last sample, CPHA=1 shows bit 0.
            if (!CPHA) tx_shift_d = tx_data;
            miso_d = first_bit(CPHA ? tx_shift_q : tx_data);
          end else begin
            tx_shift_d = tx_adv;
            miso_d     = first_bit(tx_adv);
          end
        end

        // A completing sample in this cycle has already zeroed bitcnt_d.
        if (ssel_rise) begin
          state_d     = IDLE;
          frame_err_d = (bitcnt_d != '0);
          bitcnt_d    = '0;
          miso_d      = 1'b0;
          miso_oe_d   = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        bitcnt_d  = '0;
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
      end
    endcase
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_frame.sv
// Five slave configurations driven by a bit-banged SPI master; results are
// compared against a frame-level model of received words, flags and MISO data.
module tb_spi_slave_frame;
  import spi_pkg::*;

  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [4:0] sck_v, mosi_v, ssel_v, ack_v;
  logic [4:0] miso_w, oe_w, valid_w, ovr_w, ferr_w, busy_w;

  logic [63:0] tx0, rx0;
  logic [7:0]  tx1, rx1, tx2, rx2, tx3, rx3;
  logic [15:0] tx4, rx4;

  int fb_t   [5] = '{64, 8, 8, 8, 16};
  bit cpol_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit cpha_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit msb_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic [63:0] m_rx    [5];
  bit          m_valid [5];
  int          m_ovr   [5];
  int          m_ferr  [5];

  int ovr_cnt  [5];
  int ferr_cnt [5];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_slave_frame #(.FRAME_BITS(64), .CPOL(MODE0[1]), .CPHA(MODE0[0]), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .sck(sck_v[0]), .mosi(mosi_v[0]), .ssel_n(ssel_v[0]),
    .miso(miso_w[0]), .miso_oe(oe_w[0]), .tx_data(tx0), .rx_data(rx0), .rx_valid(valid_w[0]),
    .rx_ack(ack_v[0]), .rx_overrun(ovr_w[0]), .frame_err(ferr_w[0]), .busy(busy_w[0]));

  spi_slave_frame #(.FRAME_BITS(8), .CPOL(MODE1[1]), .CPHA(MODE1[0]), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .sck(sck_v[1]), .mosi(mosi_v[1]), .ssel_n(ssel_v[1]),
    .miso(miso_w[1]), .miso_oe(oe_w[1]), .tx_data(tx1), .rx_data(rx1), .rx_valid(valid_w[1]),
    .rx_ack(ack_v[1]), .rx_overrun(ovr_w[1]), .frame_err(ferr_w[1]), .busy(busy_w[1]));

  spi_slave_frame #(.FRAME_BITS(8), .CPOL(MODE2[1]), .CPHA(MODE2[0]), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .sck(sck_v[2]), .mosi(mosi_v[2]), .ssel_n(ssel_v[2]),
    .miso(miso_w[2]), .miso_oe(oe_w[2]), .tx_data(tx2), .rx_data(rx2), .rx_valid(valid_w[2]),
    .rx_ack(ack_v[2]), .rx_overrun(ovr_w[2]), .frame_err(ferr_w[2]), .busy(busy_w[2]));

  spi_slave_frame #(.FRAME_BITS(8), .CPOL(MODE3[1]), .CPHA(MODE3[0]), .MSB_FIRST(1'b1), .SYNC_STAGES(3)) u3 (
    .clk(clk), .rst(rst), .sck(sck_v[3]), .mosi(mosi_v[3]), .ssel_n(ssel_v[3]),
    .miso(miso_w[3]), .miso_oe(oe_w[3]), .tx_data(tx3), .rx_data(rx3), .rx_valid(valid_w[3]),
    .rx_ack(ack_v[3]), .rx_overrun(ovr_w[3]), .frame_err(ferr_w[3]), .busy(busy_w[3]));

  spi_slave_frame #(.FRAME_BITS(16), .CPOL(MODE0[1]), .CPHA(MODE0[0]), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u4 (
    .clk(clk), .rst(rst), .sck(sck_v[4]), .mosi(mosi_v[4]), .ssel_n(ssel_v[4]),
    .miso(miso_w[4]), .miso_oe(oe_w[4]), .tx_data(tx4), .rx_data(rx4), .rx_valid(valid_w[4]),
    .rx_ack(ack_v[4]), .rx_overrun(ovr_w[4]), .frame_err(ferr_w[4]), .busy(busy_w[4]));

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      ovr_cnt[i]  <= ovr_cnt[i]  + (ovr_w[i[2:0]]  ? 1 : 0);
      ferr_cnt[i] <= ferr_cnt[i] + (ferr_w[i[2:0]] ? 1 : 0);
    end
  end

  function automatic logic [63:0] mask_of(input int idx);
    return (fb_t[idx] == 64) ? '1 : ((64'd1 << fb_t[idx]) - 64'd1);
  endfunction

  function automatic logic [63:0] get_rx(input int idx);
    case (idx)
      0:       return rx0;
      1:       return {56'd0, rx1};
      2:       return {56'd0, rx2};
      3:       return {56'd0, rx3};
      4:       return {48'd0, rx4};
      default: return '0;
    endcase
  endfunction

  task automatic set_tx(input int idx, input logic [63:0] v);
    case (idx)
      0:       tx0 = v;
      1:       tx1 = v[7:0];
      2:       tx2 = v[7:0];
      3:       tx3 = v[7:0];
      default: tx4 = v[15:0];
    endcase
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sel(input int idx);
    ssel_v[idx[2:0]] = 1'b0;
    #100;
  endtask

  task automatic desel(input int idx);
    ssel_v[idx[2:0]] = 1'b1;
    #100;
  endtask

  // Bit-bang nsend bits of data; returns the word assembled from MISO.
  task automatic frame(input int idx, input logic [63:0] data, input int nsend, output logic [63:0] cap);
    logic [2:0] ix;
    int n;
    int pos;
    ix  = idx[2:0];
    n   = fb_t[idx];
    cap = '0;
    for (int i = 0; i < nsend; i++) begin
      pos = msb_t[idx] ? (n - 1 - i) : i;
      if (!cpha_t[idx]) begin
        mosi_v[ix] = data[pos[5:0]];
        #HALF;
        sck_v[ix] = ~cpol_t[idx];
        cap[pos[5:0]] = miso_w[ix];
        #HALF;
        sck_v[ix] = cpol_t[idx];
      end else begin
        sck_v[ix] = ~cpol_t[idx];
        mosi_v[ix] = data[pos[5:0]];
        #HALF;
        sck_v[ix] = cpol_t[idx];
        cap[pos[5:0]] = miso_w[ix];
        #HALF;
      end
    end
    if (!cpha_t[idx]) #HALF;
  endtask

  task automatic model_done(input int idx, input logic [63:0] d);
    if (m_valid[idx]) m_ovr[idx]++;
    m_rx[idx]    = d & mask_of(idx);
    m_valid[idx] = 1'b1;
  endtask

  task automatic wait_valid(input int idx);
    for (int k = 0; k < 20 && !valid_w[idx[2:0]]; k++) @(negedge clk);
  endtask

  task automatic ack(input int idx);
    @(posedge clk); #2;
    ack_v[idx[2:0]] = 1'b1;
    @(posedge clk); #2;
    ack_v[idx[2:0]] = 1'b0;
    m_valid[idx] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_state(input string tag, input int idx);
    check({tag, "_rx"},    get_rx(idx),                  m_rx[idx]);
    check({tag, "_valid"}, 64'(valid_w[idx[2:0]]),       64'(m_valid[idx]));
    check({tag, "_ovr"},   64'(ovr_cnt[idx]),            64'(m_ovr[idx]));
    check({tag, "_ferr"},  64'(ferr_cnt[idx]),           64'(m_ferr[idx]));
  endtask

  initial begin
    logic [63:0] cap, cap2, txv, d1, d2;
    int idx;
    bit burst;

    sck_v  = 5'b01100;
    mosi_v = '0;
    ssel_v = '1;
    ack_v  = '0;
    tx0 = '0; tx1 = '0; tx2 = '0; tx3 = '0; tx4 = '0;
    for (int i = 0; i < 5; i++) begin
      m_rx[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 0; m_ferr[i] = 0;
    end

    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(valid_w), 64'd0);
    check("rst_busy",  64'(busy_w),  64'd0);
    check("rst_oe",    64'(oe_w),    64'd0);
    check("rst_miso",  64'(miso_w),  64'd0);
    check("rst_rx0",   rx0,          64'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;

    // Mode 0, 64-bit MSB-first.
    set_tx(0, 64'hA5A5_0000_FFFF_1234);
    sel(0);
    check("t1_busy", 64'(busy_w[0]), 64'd1);
    check("t1_oe",   64'(oe_w[0]),   64'd1);
    frame(0, 64'hDEAD_BEEF_0123_4567, 64, cap);
    model_done(0, 64'hDEAD_BEEF_0123_4567);
    wait_valid(0);
    check_state("t1", 0);
    check("t1_miso_word", cap, 64'hA5A5_0000_FFFF_1234);
    desel(0);
    check("t1_idle_busy", 64'(busy_w[0]), 64'd0);
    check("t1_idle_oe",   64'(oe_w[0]),   64'd0);
    check("t1_idle_miso", 64'(miso_w[0]), 64'd0);
    ack(0);
    check("t1_acked", 64'(valid_w[0]), 64'd0);

    // Modes 1..3, 8-bit.
    for (int i = 1; i <= 3; i++) begin
      set_tx(i, 64'hC3);
      sel(i);
      frame(i, 64'h3C, 8, cap);
      model_done(i, 64'h3C);
      wait_valid(i);
      check_state($sformatf("t2_m%0d", i), i);
      check($sformatf("t2_m%0d_miso", i), cap, 64'hC3);
      desel(i);
      ack(i);
    end

    // LSB-first, 16-bit.
    set_tx(4, 64'h5A3C);
    sel(4);
    frame(4, 64'h8001, 16, cap);
    model_done(4, 64'h8001);
    wait_valid(4);
    check_state("t3", 4);
    check("t3_miso", cap, 64'h5A3C);
    desel(4);
    ack(4);

    // Burst of two frames under one select, no acknowledge.
    sel(3);
    frame(3, 64'h11, 8, cap);
    model_done(3, 64'h11);
    wait_valid(3);
    check_state("t4_f1", 3);
    frame(3, 64'h22, 8, cap2);
    model_done(3, 64'h22);
    desel(3);
    check_state("t4_f2", 3);
    check("t4_miso1", cap,  64'hC3);
    check("t4_miso2", cap2, 64'hC3);
    ack(3);

    // Truncated frame: 5 of 8 bits.
    sel(2);
    frame(2, 64'h5A, 8, cap);
    model_done(2, 64'h5A);
    desel(2);
    sel(2);
    frame(2, 64'hFF, 5, cap);
    desel(2);
    m_ferr[2]++;
    check_state("t5", 2);

    // Reset mid-frame, then a clean frame.
    sel(0);
    frame(0, 64'hFFFF_FFFF_FFFF_FFFF, 30, cap);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_rx[i] = '0; m_valid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("t6_rst_busy",  64'(busy_w), 64'd0);
    check("t6_rst_valid", 64'(valid_w), 64'd0);
    check("t6_rst_oe",    64'(oe_w), 64'd0);
    ssel_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check_state("t6_after_rst", 0);
    check_state("t6_other", 2);
    sel(0);
    frame(0, 64'h1, 64, cap);
    model_done(0, 64'h1);
    wait_valid(0);
    desel(0);
    check_state("t6", 0);
    ack(0);

    // Randomised frames and bursts across all configurations.
    for (int r = 0; r < 10; r++) begin
      idx   = int'($urandom_range(0, 4));
      txv   = {$urandom, $urandom};
      d1    = {$urandom, $urandom};
      d2    = {$urandom, $urandom};
      burst = ($urandom_range(0, 1) == 1);
      set_tx(idx, txv);
      sel(idx);
      frame(idx, d1, fb_t[idx], cap);
      model_done(idx, d1);
      if (burst) begin
        frame(idx, d2, fb_t[idx], cap2);
        model_done(idx, d2);
        check($sformatf("rnd%0d_miso2", r), cap2, txv & mask_of(idx));
      end
      desel(idx);
      check_state($sformatf("rnd%0d", r), idx);
      check($sformatf("rnd%0d_miso", r), cap, txv & mask_of(idx));
      if ($urandom_range(0, 1) == 1) begin
        ack(idx);
        check($sformatf("rnd%0d_ack", r), 64'(valid_w[idx[2:0]]), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
Parametrised SPI slave receiver/transmitter, the successor to the fixed 64-bit mode-0 receive-only SPI slave.
- Configurable frame width, SPI mode (CPOL/CPHA), bit order and synchroniser depth.
- Drives MISO from a host-loaded transmit word.
- Supports back-to-back frames within one SSEL assertion, and flags truncated frames and receive overruns.
- Sits between the off-chip SPI master pins and the fabric register/command logic in the clk domain.

Parameters:
FRAME_BITS, 64, bits per frame (2..256)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first on MOSI and MISO
SYNC_STAGES, 2, flops in each pin synchroniser (>=2)

Ports:
clk  in  1  system clock; SCK must be <= clk/4
rst  in  1  asynchronous, active-high reset
sck  in  1  SPI clock pin (asynchronous)
mosi  in  1  SPI data in (asynchronous)
ssel_n  in  1  SPI select, active low (asynchronous)
miso  out  1  SPI data out
miso_oe  out  1  high while selected (pad tristate control)
tx_data  in  FRAME_BITS  word to transmit; latched at frame start
rx_data  out  FRAME_BITS  last complete received frame
rx_valid  out  1  rx_data holds an unacknowledged frame
rx_ack  in  1  consumer acknowledge; clears rx_valid
rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid=1
frame_err  out  1  one-cycle pulse: SSEL released with a partial frame
busy  out  1  high in ACTIVE state

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all outputs 0, except miso = 0 and miso_oe = 0. Shift registers, bit counter and state are cleared. rst asserted mid-frame aborts the frame with no flags raised.
- Synchronisation: sck, mosi and ssel_n each pass through SYNC_STAGES flops. Edges are detected from the last two stages.
- Edge decode:
  - lead = SCK edge leaving the CPOL level; trail = SCK edge returning to it.
  - sample_edge = lead if CPHA=0, else trail.
  - shift_edge = the other edge.
- Reserved states: IDLE (00), ACTIVE (01). Other encodings recover to IDLE.
- IDLE -> ACTIVE on synchronised ssel_n falling edge:
  - bitcnt <= 0; tx_shift <= tx_data; miso_oe <= 1.
  - CPHA=0: miso presents the first bit in the same cycle.
- ACTIVE, sample_edge: rx_shift shifts in the synchronised mosi (toward LSB if MSB_FIRST, else toward MSB); bitcnt++.
- ACTIVE, shift_edge: tx_shift advances and miso updates to the next bit.
  - CPHA=0: the shift_edge immediately following the final sample of a frame loads tx_data for the next frame.
  - CPHA=1: the first lead edge presents bit 0.
- Frame completion, when bitcnt reaches FRAME_BITS on a sample_edge:
  - rx_data <= completed word (including the bit just sampled), registered in the next clk cycle.
  - rx_valid <= 1 in that same cycle.
  - bitcnt <= 0; stay ACTIVE, so further frames continue in burst.
  - If rx_valid was already 1 and not being acked in that cycle: rx_data is overwritten and rx_overrun pulses.
- rx_ack: clears rx_valid the cycle after. If completion and ack coincide, completion wins: rx_valid stays 1 and no overrun is raised.
- ACTIVE -> IDLE on ssel_n rising edge:
  - miso_oe <= 0; miso <= 0.
  - If bitcnt != 0: frame_err pulses and partial data is discarded; rx_data and rx_valid are unchanged.
- Simultaneous events: an ssel_n rise in the same cycle as a completing sample_edge means the frame completes first, then the block returns to IDLE with no frame_err.
- Other rules:
  - An ssel_n fall while ACTIVE is impossible and is ignored.
  - SCK edges in IDLE are ignored.
- bitcnt width: $clog2(FRAME_BITS+1).
- Latency: pin edge to internal action = SYNC_STAGES+1 clk cycles.

Decomposition:
- Package spi_pkg:
  - state encoding constants.
  - function for bit-counter width.
  - SPI mode constants MODE0..MODE3 mapping to CPOL/CPHA.
- Sub-module spi_sync_edge (parameter STAGES): synchroniser plus rise/fall pulse outputs. Instantiated three times, for sck, mosi and ssel_n (mosi uses only the level output).

Test Plan:
1. Mode 0, FRAME_BITS=64, MSB_FIRST=1, tx_data=64'hA5A5_0000_FFFF_1234; master sends 64'hDEAD_BEEF_0123_4567 -> rx_data=64'hDEADBEEF01234567 with rx_valid=1 after the last edge, and the master captures 64'hA5A50000FFFF1234 on MISO.
2. Modes 1, 2 and 3 each with FRAME_BITS=8, send 8'h3C -> rx_data=8'h3C, and MISO echoes tx_data=8'hC3 correctly for each mode.
3. MSB_FIRST=0, FRAME_BITS=16, master sends LSB-first 16'h8001 -> rx_data=16'h8001.
4. Burst: two 8-bit frames 8'h11 then 8'h22 under one SSEL, no rx_ack -> first rx_valid shows 8'h11; second frame sets rx_data=8'h22 and pulses rx_overrun once.
5. SSEL released after 5 of 8 bits -> frame_err pulses one cycle, rx_data keeps its prior value, rx_valid unchanged.
6. rst asserted after 30 of 64 bits, then released with a full new frame 64'h1 -> no flags during the reset, and the following frame yields rx_data=64'h1.
